cosine_sim_stream: RTL and testbench
====================================

Name: cosine_sim_stream

Overview:
- Parametrised successor to the fixed-width cosine similarity engine.
- Takes two signed fixed-point vectors of run-time length, streamed LANES element pairs per beat over a valid/ready handshake.
- Accumulates dot(a,b), |a|^2 and |b|^2, then runs a bit-serial integer square root and a restoring divide.
- Returns the cosine similarity as signed Q1.OUT_FRAC; sits between the feature-vector buffer and the match/compare logic.

Parameters:
- DATA_W, 16: element width, signed two's complement.
- LANES, 1: element pairs accepted per beat.
- MAX_LEN, 64: maximum vector length in elements.
- OUT_FRAC, 15: fractional bits of the result.
- Derived ACC_W = 2*DATA_W + $clog2(MAX_LEN) (38 at defaults). Used for dot and norm accumulators.
- Derived LEN_W = $clog2(MAX_LEN+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  pulse; begins an operation when idle
- len  in  LEN_W  vector length in elements, sampled on accepted start
- in_valid  in  1  element beat valid
- in_ready  out  1  element beat accepted when in_valid & in_ready
- in_a  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- in_b  in  LANES*DATA_W  same packing as in_a
- res_valid  out  1  result valid
- res_ready  in  1  result consumed when res_valid & res_ready
- similarity  out  OUT_FRAC+2  signed Q1.OUT_FRAC result
- zero_vec  out  1  set with the result if either norm was zero
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, rst_n low): state IDLE; all accumulators and counters 0; in_ready=0, res_valid=0, similarity=0, zero_vec=0, busy=0.
- IDLE:
  - start=1 latches len rounded down to a multiple of LANES; clears accumulators.
  - If latched len>0, go to ACCUM. If latched len=0, go to DONE with similarity=0 and zero_vec=1.
- ACCUM:
  - in_ready=1.
  - Each accepted beat adds the sum over lanes of a*b to dot (signed), a*a to na and b*b to nb (unsigned).
  - Beat counter increments; after the beat completing len elements, go to SQRT.
  - in_valid low stalls with no state change.
- SQRT:
  - P = na*nb (2*ACC_W bits).
  - Restoring integer square root, one result bit per cycle, ACC_W cycles; S = floor(sqrt(P)).
  - If S=0, skip to DONE with similarity=0 and zero_vec=1.
- DIV:
  - Restoring divide Q = floor((|dot| << OUT_FRAC) / S), one bit per cycle, OUT_FRAC+2 cycles.
  - Saturate Q to 2^OUT_FRAC.
  - Apply the sign of dot; truncation is toward zero.
- DONE:
  - res_valid=1; similarity and zero_vec held stable until res_valid & res_ready, then go to IDLE.
  - The handshake may complete in the first DONE cycle.
- Latency: res_valid rises exactly ACC_W+OUT_FRAC+3 cycles after the edge accepting the last beat (56 at defaults). The zero-norm path is shorter.
- start while busy=1 is ignored; the in-flight operation is unaffected.
- in_valid outside ACCUM is ignored; in_ready is 0 there.
- Reset mid-operation aborts immediately; no result is produced. The first start after reset release operates normally.
- Full-scale inputs (-2^(DATA_W-1) in every lane, len=MAX_LEN) must not overflow any accumulator.

Test Plan:
- Identical vectors: a=b=[1,1,1,1,1], len=5 -> similarity=32768 (+1.0), zero_vec=0, res_valid exactly 56 cycles after the last beat.
- Opposite vectors: a=[1,2,3], b=[-1,-2,-3], len=3 -> similarity=-32768.
- Partial correlation: a=[3,4], b=[4,3] -> similarity=31457 (floor(0.96*32768)).
- Orthogonal vectors: a=[1,0], b=[0,1] -> similarity=0, zero_vec=0.
- Zero cases:
  - a=[0,0,0], b=[1,2,3] -> similarity=0, zero_vec=1.
  - len=0 -> similarity=0, zero_vec=1 with no beats consumed.
- Handshake and robustness, run with LANES=2:
  - Randomly stall in_valid: result is unchanged.
  - Hold res_ready=0 for 20 cycles: outputs stay stable.
  - Extra start while busy: ignored.
  - rst_n pulse mid-ACCUM, then a new op with all-max-negative inputs, len=MAX_LEN -> similarity=32768, no stale result.

Source files
------------

// File: rtl/cosine_sim_stream.sv
// Streaming cosine similarity: accumulates dot(a,b), |a|^2 and |b|^2, then
// computes floor(sqrt(|a|^2*|b|^2)) bit-serially and divides to a signed Q1.OUT_FRAC.
module cosine_sim_stream #(
  parameter int DATA_W   = 16,
  parameter int LANES    = 1,
  parameter int MAX_LEN  = 64,
  parameter int OUT_FRAC = 15,
  localparam int ACC_W   = 2*DATA_W + $clog2(MAX_LEN),
  localparam int LEN_W   = $clog2(MAX_LEN+1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [LEN_W-1:0]           len,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LANES*DATA_W-1:0]    in_a,
  input  logic [LANES*DATA_W-1:0]    in_b,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [OUT_FRAC+1:0]        similarity,
  output logic                       zero_vec,
  output logic                       busy
);

  localparam int PROD_W = 2*DATA_W;
  localparam int P_W    = 2*ACC_W;
  localparam int Q_W    = OUT_FRAC+2;
  localparam int CNT_W  = $clog2((ACC_W > Q_W ? ACC_W : Q_W) + 1);

  typedef enum logic [2:0] {IDLE, ACCUM, SQRT, DIV, FIN, DONE} state_t;
  state_t state_reg, state_next;

  logic signed [ACC_W-1:0] dot_reg;
  logic [ACC_W-1:0]        na_reg, nb_reg;
  logic [LEN_W-1:0]        tgt_reg, beat_reg;
  logic [CNT_W-1:0]        cnt_reg;
  logic [ACC_W:0]          sq_rem_reg, dv_rem_reg;
  logic [ACC_W-1:0]        root_reg;
  logic [Q_W-1:0]          num_reg, q_reg;
  logic [Q_W-1:0]          sim_reg;
  logic                    zero_reg;

  logic signed [PROD_W-1:0] p_ab [LANES];
  logic signed [PROD_W-1:0] p_aa [LANES];
  logic signed [PROD_W-1:0] p_bb [LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic signed [DATA_W-1:0] a_l, b_l;
    assign a_l = in_a[gi*DATA_W +: DATA_W];
    assign b_l = in_b[gi*DATA_W +: DATA_W];
    assign p_ab[gi] = a_l * b_l;
    assign p_aa[gi] = a_l * a_l;
    assign p_bb[gi] = b_l * b_l;
  end

  logic signed [ACC_W-1:0] sum_ab;
  logic [ACC_W-1:0]        sum_aa, sum_bb;
  always_comb begin
    sum_ab = '0;
    sum_aa = '0;
    sum_bb = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_ab = sum_ab + {{(ACC_W-PROD_W){p_ab[i][PROD_W-1]}}, p_ab[i]};
      // Squares are never negative, so zero extension is exact.
      sum_aa = sum_aa + {{(ACC_W-PROD_W){1'b0}}, p_aa[i]};
      sum_bb = sum_bb + {{(ACC_W-PROD_W){1'b0}}, p_bb[i]};
    end
  end

  logic [LEN_W-1:0] tgt_len;
  logic             in_fire, last_beat;
  assign tgt_len   = LEN_W'(int'(len) / LANES);
  assign in_fire   = (state_reg == ACCUM) && in_valid;
  assign last_beat = in_fire && (beat_reg == tgt_reg - 1'b1);

  logic [P_W-1:0]   prod;
  logic [1:0]       pair;
  logic [ACC_W+2:0] sq_t, sq_trial;
  logic             sq_ge, sq_last;
  logic [ACC_W:0]   sq_rem_nx;
  logic [ACC_W-1:0] root_nx, abs_dot;
  assign prod      = P_W'(na_reg) * P_W'(nb_reg);
  assign pair      = prod[(P_W-2) - 2*int'(cnt_reg) +: 2];
  assign sq_t      = {sq_rem_reg, pair};
  assign sq_trial  = {1'b0, root_reg, 2'b01};
  assign sq_ge     = sq_t >= sq_trial;
  assign sq_rem_nx = sq_ge ? (ACC_W+1)'(sq_t - sq_trial) : (ACC_W+1)'(sq_t);
  assign root_nx   = {root_reg[ACC_W-2:0], sq_ge};
  assign sq_last   = cnt_reg == CNT_W'(ACC_W-1);
  assign abs_dot   = dot_reg[ACC_W-1] ? ACC_W'(-dot_reg) : ACC_W'(dot_reg);

  // Since |dot| <= S, only the low Q_W quotient bits can be non-zero.
  logic [ACC_W+1:0] dv_t;
  logic             dv_ge, dv_last;
  logic [ACC_W:0]   dv_rem_nx;
  logic [Q_W-1:0]   q_one, q_sat;
  assign dv_t      = {dv_rem_reg, num_reg[Q_W-1]};
  assign dv_ge     = dv_t >= {2'b00, root_reg};
  assign dv_rem_nx = dv_ge ? (ACC_W+1)'(dv_t - {2'b00, root_reg}) : (ACC_W+1)'(dv_t);
  assign dv_last   = cnt_reg == CNT_W'(Q_W-1);
  assign q_one     = Q_W'(1) << OUT_FRAC;
  assign q_sat     = (q_reg > q_one) ? q_one : q_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = (tgt_len == '0) ? DONE : ACCUM;
      ACCUM:   if (last_beat) state_next = SQRT;
      SQRT:    if (sq_last) state_next = (root_nx == '0) ? DONE : DIV;
      DIV:     if (dv_last) state_next = FIN;
      FIN:     state_next = DONE;
      DONE:    if (res_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dot_reg <= '0; na_reg <= '0; nb_reg <= '0;
      tgt_reg <= '0; beat_reg <= '0; cnt_reg <= '0;
      sq_rem_reg <= '0; root_reg <= '0; dv_rem_reg <= '0;
      num_reg <= '0; q_reg <= '0; sim_reg <= '0; zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (start) begin
          tgt_reg <= tgt_len; beat_reg <= '0; cnt_reg <= '0;
          dot_reg <= '0; na_reg <= '0; nb_reg <= '0;
          sq_rem_reg <= '0; root_reg <= '0;
          if (tgt_len == '0) begin
            sim_reg <= '0; zero_reg <= 1'b1;
          end
        end
        ACCUM: if (in_fire) begin
          dot_reg  <= dot_reg + sum_ab;
          na_reg   <= na_reg + sum_aa;
          nb_reg   <= nb_reg + sum_bb;
          beat_reg <= beat_reg + 1'b1;
        end
        SQRT: begin
          sq_rem_reg <= sq_rem_nx;
          root_reg   <= root_nx;
          cnt_reg    <= sq_last ? '0 : cnt_reg + 1'b1;
          if (sq_last) begin
            dv_rem_reg <= (ACC_W+1)'(abs_dot >> 2);
            num_reg    <= {abs_dot[1:0], {OUT_FRAC{1'b0}}};
            q_reg      <= '0;
            if (root_nx == '0) begin
              sim_reg <= '0; zero_reg <= 1'b1;
            end
          end
        end
        DIV: begin
          dv_rem_reg <= dv_rem_nx;
          num_reg    <= {num_reg[Q_W-2:0], 1'b0};
          q_reg      <= {q_reg[Q_W-2:0], dv_ge};
          cnt_reg    <= cnt_reg + 1'b1;
        end
        FIN: begin
          sim_reg  <= dot_reg[ACC_W-1] ? Q_W'(-q_sat) : q_sat;
          zero_reg <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_reg == ACCUM);
  assign res_valid  = (state_reg == DONE);
  assign busy       = (state_reg != IDLE);
  assign similarity = sim_reg;
  assign zero_vec   = zero_reg;

endmodule

// File: tb/tb_cosine_sim_stream.sv
// Directed bench for cosine_sim_stream: a LANES=1 instance for the arithmetic
// cases and a LANES=2 instance for handshake, stall, abort and full-scale cases.
module tb_cosine_sim_stream;
  localparam int DW = 16;
  localparam int LW = 7;
  localparam int SW = 17;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic            start1, in_valid1, res_ready1, in_ready1, res_valid1, zero_vec1, busy1;
  logic [LW-1:0]   len1;
  logic [DW-1:0]   in_a1, in_b1;
  logic [SW-1:0]   sim1;

  logic            start2, in_valid2, res_ready2, in_ready2, res_valid2, zero_vec2, busy2;
  logic [LW-1:0]   len2;
  logic [2*DW-1:0] in_a2, in_b2;
  logic [SW-1:0]   sim2;

  cosine_sim_stream #(.DATA_W(DW), .LANES(1), .MAX_LEN(64), .OUT_FRAC(15)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .len(len1), .in_valid(in_valid1),
    .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1), .res_valid(res_valid1),
    .res_ready(res_ready1), .similarity(sim1), .zero_vec(zero_vec1), .busy(busy1));

  cosine_sim_stream #(.DATA_W(DW), .LANES(2), .MAX_LEN(64), .OUT_FRAC(15)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .len(len2), .in_valid(in_valid2),
    .in_ready(in_ready2), .in_a(in_a2), .in_b(in_b2), .res_valid(res_valid2),
    .res_ready(res_ready2), .similarity(sim2), .zero_vec(zero_vec2), .busy(busy2));

  int errors = 0;
  int checks = 0;
  int va [64];
  int vb [64];
  int got_sim, got_zv, got_lat, got_beats;
  bit stable_ok;

  task automatic run1(input int n);
    int t;
    bit acc;
    start1 = 1'b1; len1 = LW'(n);
    @(posedge clk); #1 start1 = 1'b0;
    got_beats = 0;
    for (int i = 0; i < n; i++) begin
      in_valid1 = 1'b1; in_a1 = DW'(va[i]); in_b1 = DW'(vb[i]);
      t = 0;
      acc = 1'b0;
      while (!acc && t < 100) begin
        acc = in_ready1;
        @(posedge clk); #1;
        t++;
      end
      if (acc) got_beats++;
    end
    in_valid1 = 1'b0;
    got_lat = 0;
    while (!res_valid1 && got_lat < 300) begin
      @(posedge clk); #1;
      got_lat++;
    end
    checks++;
    if (!res_valid1) begin
      errors++; $display("FAIL run1_timeout: res_valid=%0b required 1 (beats=%0d)", res_valid1, got_beats);
    end
    got_sim = int'($signed(sim1));
    got_zv  = int'(zero_vec1);
    @(posedge clk); #1;
  endtask

  task automatic run2(input int n, input bit stall, input int hold, input bit busy_start);
    int t;
    bit acc;
    res_ready2 = (hold == 0);
    start2 = 1'b1; len2 = LW'(n);
    @(posedge clk); #1 start2 = 1'b0;
    got_beats = 0; t = 0;
    while (got_beats < n/2 && t < 500) begin
      in_valid2 = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      in_a2 = {DW'(va[2*got_beats+1]), DW'(va[2*got_beats])};
      in_b2 = {DW'(vb[2*got_beats+1]), DW'(vb[2*got_beats])};
      start2 = busy_start && (got_beats == 1);
      if (busy_start) len2 = LW'(2);
      acc = in_valid2 && in_ready2;
      @(posedge clk); #1;
      t++;
      if (acc) got_beats++;
    end
    in_valid2 = 1'b0; start2 = 1'b0;
    got_lat = 0;
    while (!res_valid2 && got_lat < 300) begin
      @(posedge clk); #1;
      got_lat++;
    end
    checks++;
    if (!res_valid2) begin
      errors++; $display("FAIL run2_timeout: res_valid=%0b required 1 (beats=%0d)", res_valid2, got_beats);
    end
    got_sim = int'($signed(sim2));
    got_zv  = int'(zero_vec2);
    stable_ok = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); #1;
      if (res_valid2 !== 1'b1 || int'($signed(sim2)) !== got_sim || int'(zero_vec2) !== got_zv)
        stable_ok = 1'b0;
    end
    res_ready2 = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    if (in_ready1 !== 1'b0)  begin errors++; $display("FAIL reset_in_ready1: got %0b required 0", in_ready1); end
    if (res_valid1 !== 1'b0) begin errors++; $display("FAIL reset_res_valid1: got %0b required 0", res_valid1); end
    if (sim1 !== '0)         begin errors++; $display("FAIL reset_sim1: got %0d required 0", sim1); end
    if (zero_vec1 !== 1'b0)  begin errors++; $display("FAIL reset_zero_vec1: got %0b required 0", zero_vec1); end
    if (busy1 !== 1'b0)      begin errors++; $display("FAIL reset_busy1: got %0b required 0", busy1); end
    if (in_ready2 !== 1'b0)  begin errors++; $display("FAIL reset_in_ready2: got %0b required 0", in_ready2); end
    if (res_valid2 !== 1'b0) begin errors++; $display("FAIL reset_res_valid2: got %0b required 0", res_valid2); end
    if (busy2 !== 1'b0)      begin errors++; $display("FAIL reset_busy2: got %0b required 0", busy2); end
    checks += 8;
    $display("reset: in_ready=%0b res_valid=%0b sim=%0d zero_vec=%0b busy=%0b", in_ready1, res_valid1, sim1, zero_vec1, busy1);
  endtask

  task automatic test_identical();
    for (int i = 0; i < 5; i++) begin va[i] = 1; vb[i] = 1; end
    run1(5);
    if (got_sim !== 32768) begin errors++; $display("FAIL identical_sim: got %0d required 32768", got_sim); end
    if (got_zv !== 0)      begin errors++; $display("FAIL identical_zero_vec: got %0d required 0", got_zv); end
    if (got_lat !== 56)    begin errors++; $display("FAIL identical_latency: got %0d required 56", got_lat); end
    checks += 3;
    $display("identical: sim=%0d zero_vec=%0d latency=%0d", got_sim, got_zv, got_lat);
  endtask

  task automatic test_opposite();
    for (int i = 0; i < 3; i++) begin va[i] = i+1; vb[i] = -(i+1); end
    run1(3);
    if (got_sim !== -32768) begin errors++; $display("FAIL opposite_sim: got %0d required -32768", got_sim); end
    if (got_zv !== 0)       begin errors++; $display("FAIL opposite_zero_vec: got %0d required 0", got_zv); end
    checks += 2;
    $display("opposite: sim=%0d zero_vec=%0d", got_sim, got_zv);
  endtask

  task automatic test_partial();
    va[0] = 3; va[1] = 4; vb[0] = 4; vb[1] = 3;
    run1(2);
    if (got_sim !== 31457) begin errors++; $display("FAIL partial_pos_sim: got %0d required 31457", got_sim); end
    checks++;
    $display("partial +: sim=%0d", got_sim);
    vb[0] = -4; vb[1] = -3;
    run1(2);
    if (got_sim !== -31457) begin errors++; $display("FAIL partial_neg_sim: got %0d required -31457", got_sim); end
    checks++;
    $display("partial -: sim=%0d", got_sim);
  endtask

  task automatic test_orthogonal();
    va[0] = 1; va[1] = 0; vb[0] = 0; vb[1] = 1;
    run1(2);
    if (got_sim !== 0) begin errors++; $display("FAIL orthogonal_sim: got %0d required 0", got_sim); end
    if (got_zv !== 0)  begin errors++; $display("FAIL orthogonal_zero_vec: got %0d required 0", got_zv); end
    checks += 2;
    $display("orthogonal: sim=%0d zero_vec=%0d", got_sim, got_zv);
  endtask

  task automatic test_zero_vec();
    for (int i = 0; i < 3; i++) begin va[i] = 0; vb[i] = i+1; end
    run1(3);
    if (got_sim !== 0) begin errors++; $display("FAIL zero_a_sim: got %0d required 0", got_sim); end
    if (got_zv !== 1)  begin errors++; $display("FAIL zero_a_zero_vec: got %0d required 1", got_zv); end
    checks += 2;
    $display("zero a: sim=%0d zero_vec=%0d", got_sim, got_zv);
  endtask

  task automatic test_zero_len();
    bit seen;
    int s;
    int z;
    seen = 1'b0;
    in_valid1 = 1'b1; in_a1 = DW'(5); in_b1 = DW'(7);
    start1 = 1'b1; len1 = '0;
    @(posedge clk); #1 start1 = 1'b0;
    if (in_ready1) seen = 1'b1;
    s = int'($signed(sim1));
    z = int'(zero_vec1);
    if (res_valid1 !== 1'b1) begin errors++; $display("FAIL zero_len_valid: got %0b required 1", res_valid1); end
    if (s !== 0) begin errors++; $display("FAIL zero_len_sim: got %0d required 0", s); end
    if (z !== 1) begin errors++; $display("FAIL zero_len_zero_vec: got %0d required 1", z); end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (in_ready1) seen = 1'b1;
    end
    in_valid1 = 1'b0;
    if (seen !== 1'b0) begin errors++; $display("FAIL zero_len_in_ready: got %0b required 0", seen); end
    checks += 4;
    $display("zero len: res_valid=1 sim=%0d zero_vec=%0d in_ready_seen=%0b", s, z, seen);
  endtask

  task automatic test_stall();
    va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4; va[4] = 9;
    vb[0] = 2; vb[1] = 1; vb[2] = 4; vb[3] = 3; vb[4] = 9;
    run2(5, 1'b1, 0, 1'b0);
    if (got_sim !== 30583) begin errors++; $display("FAIL stall_sim: got %0d required 30583", got_sim); end
    if (got_beats !== 2)   begin errors++; $display("FAIL stall_beats: got %0d required 2", got_beats); end
    if (got_lat !== 56)    begin errors++; $display("FAIL stall_latency: got %0d required 56", got_lat); end
    checks += 3;
    $display("stall lanes=2 len=5: sim=%0d beats=%0d latency=%0d", got_sim, got_beats, got_lat);
  endtask

  task automatic test_hold();
    va[0] = 3; va[1] = 4; va[2] = 0; va[3] = 0;
    vb[0] = -4; vb[1] = -3; vb[2] = 0; vb[3] = 0;
    run2(4, 1'b0, 20, 1'b0);
    if (got_sim !== -31457)   begin errors++; $display("FAIL hold_sim: got %0d required -31457", got_sim); end
    if (stable_ok !== 1'b1)   begin errors++; $display("FAIL hold_stable: got %0b required 1", stable_ok); end
    if (res_valid2 !== 1'b0)  begin errors++; $display("FAIL hold_release: res_valid=%0b required 0", res_valid2); end
    checks += 3;
    $display("hold 20: sim=%0d stable=%0b", got_sim, stable_ok);
  endtask

  task automatic test_busy_start();
    va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
    vb[0] = 2; vb[1] = 1; vb[2] = 4; vb[3] = 3;
    run2(4, 1'b0, 0, 1'b1);
    if (got_sim !== 30583) begin errors++; $display("FAIL busy_start_sim: got %0d required 30583", got_sim); end
    if (got_beats !== 2)   begin errors++; $display("FAIL busy_start_beats: got %0d required 2", got_beats); end
    if (busy2 !== 1'b0)    begin errors++; $display("FAIL busy_start_idle: busy=%0b required 0", busy2); end
    checks += 3;
    $display("busy start: sim=%0d beats=%0d busy_after=%0b", got_sim, got_beats, busy2);
  endtask

  task automatic test_reset_abort();
    bit stale;
    for (int i = 0; i < 64; i++) begin va[i] = i+1; vb[i] = 2; end
    start2 = 1'b1; len2 = LW'(64);
    @(posedge clk); #1 start2 = 1'b0;
    in_valid2 = 1'b1; in_a2 = {DW'(7), DW'(3)}; in_b2 = {DW'(1), DW'(5)};
    repeat (5) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    if (busy2 !== 1'b0)     begin errors++; $display("FAIL abort_busy: got %0b required 0", busy2); end
    if (in_ready2 !== 1'b0) begin errors++; $display("FAIL abort_in_ready: got %0b required 0", in_ready2); end
    in_valid2 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    stale = 1'b0;
    repeat (10) begin @(posedge clk); #1; if (res_valid2 || busy2) stale = 1'b1; end
    if (stale !== 1'b0) begin errors++; $display("FAIL abort_stale: got %0b required 0", stale); end
    for (int i = 0; i < 64; i++) begin va[i] = -32768; vb[i] = -32768; end
    run2(64, 1'b0, 0, 1'b0);
    if (got_sim !== 32768) begin errors++; $display("FAIL full_scale_sim: got %0d required 32768", got_sim); end
    if (got_zv !== 0)      begin errors++; $display("FAIL full_scale_zero_vec: got %0d required 0", got_zv); end
    if (got_beats !== 32)  begin errors++; $display("FAIL full_scale_beats: got %0d required 32", got_beats); end
    checks += 6;
    $display("abort + full scale: sim=%0d zero_vec=%0d beats=%0d", got_sim, got_zv, got_beats);
  endtask

  initial begin
    rst_n = 1'b0;
    start1 = 1'b0; in_valid1 = 1'b0; res_ready1 = 1'b1; len1 = '0; in_a1 = '0; in_b1 = '0;
    start2 = 1'b0; in_valid2 = 1'b0; res_ready2 = 1'b1; len2 = '0; in_a2 = '0; in_b2 = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_identical();
    test_opposite();
    test_partial();
    test_orthogonal();
    test_zero_vec();
    test_zero_len();
    test_stall();
    test_hold();
    test_busy_start();
    test_reset_abort();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
